// File: rtl/riscv_pkg.sv
// Constants and types shared between the fetch stage and the decoder.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous in-order FIFO with a synchronous flush. DEPTH must be a power of two >= 2.
module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, wr_en, rd_en;

  assign empty = count_q == '0;
  assign full  = count_q == CW'(DEPTH);
  assign rd_en = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en = push && (!full || rd_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !rd_en)      count_d = count_q + 1'b1;
      else if (rd_en && !wr_en) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, credit-limited imem requests, redirect flush, decoder handshake.
// Defining IFETCH_PERF_CNT_EN adds fetch/stall/flush performance counter outputs.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = CW + 4;
  localparam logic [CW:0]     DEPTH_W  = FIFO_DEPTH[CW:0];
  localparam logic [XLEN-1:0] RST_ADDR = {RESET_PC[XLEN-1:2], 2'b00};

  logic            rst_q, rst_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [DW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   outstanding, fifo_count;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] tag_head;
  fetch_bundle_t   push_bundle, head;
  logic            req_fire, rsp_live, out_fire;
  logic            unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc[1:0];

  assign out_valid   = fifo_count != '0;
  assign out_fire    = out_valid && out_ready;
  // The tag FIFO holds exactly one entry per live in-flight request.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, out_fire};

  assign imem_req_valid = !rst_q && !redirect_valid && (credit_used < DEPTH_W);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_live       = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign push_bundle    = '{instr: imem_rsp_data, pc: tag_head};

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (rsp_live),
    .pop_data  (tag_head),
    .count     (outstanding)
  );

  fetch_fifo #(.WIDTH($bits(fetch_bundle_t)), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_live),
    .push_data (push_bundle),
    .pop       (out_fire),
    .pop_data  (head),
    .count     (fifo_count)
  );

  always_comb begin
    rst_d      = 1'b0;
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      // Any same-cycle response, stale or live, is consumed by this flush.
      drop_cnt_d = drop_cnt_q + DW'(outstanding) - DW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_q      <= 1'b1;
      fetch_pc_q <= RST_ADDR;
      drop_cnt_q <= '0;
    end else begin
      rst_q      <= rst_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_instr    = out_valid ? head.instr : NOP_INSTR;
  assign out_pc       = out_valid ? head.pc : RST_ADDR;
  assign out_pc_plus4 = out_pc + 32'd4;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (out_fire)               perf_fetch_d = perf_fetch_q + 32'd1;
    if (out_ready && !out_valid) perf_stall_d = perf_stall_q + 32'd1;
    if (redirect_valid)         perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the instruction decoder. Holds the program counter, issues sequential word requests to instruction memory, buffers returned instruction words in a small in-order FIFO, and presents one `{instr, pc, pc_plus4}` bundle per cycle to the decoder over a valid/ready handshake. Jump, jump-register and taken-branch redirects from execute flush all in-flight and buffered fetches and restart at the target PC.

## Interface

**Parameters**
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset.
- `FIFO_DEPTH`, default `2`: fetch buffer entries. Must be a power of two, ≥2.

**Ports**
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `imem_req_valid`, out, 1: fetch request valid.
- `imem_req_ready`, in, 1: memory accepts the request.
- `imem_req_addr`, out, 32: word-aligned fetch address. Bits [1:0] are always 0.
- `imem_rsp_valid`, in, 1: response valid. Responses return in order, ≥1 cycle after acceptance, with no backpressure.
- `imem_rsp_data`, in, 32: instruction word.
- `redirect_valid`, in, 1: redirect from jump, jump-register or taken branch.
- `redirect_pc`, in, 32: target PC. Bits [1:0] are ignored and treated as 0.
- `out_valid`, out, 1: bundle valid to the decoder.
- `out_ready`, in, 1: decoder accepts the bundle.
- `out_instr`, out, 32: instruction word.
- `out_pc`, out, 32: PC of `out_instr`.
- `out_pc_plus4`, out, 32: `out_pc + 4`, modulo 2^32. This is the link value for jumps.

## Operation

**PC register**
- `fetch_pc` resets to `RESET_PC`.
- Advances by 4 on each accepted request (`imem_req_valid && imem_req_ready`).
- Wraps modulo 2^32.

**Request credit**
- `imem_req_valid = !rst_q && !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH)`.
- `rst_q` is high for the first cycle after reset deassert, so no request is issued in that cycle.
- Every accepted request therefore has a guaranteed FIFO slot. The FIFO never overflows and never backpressures memory.

**Response tracking**
- A PC tag FIFO of the same depth records `fetch_pc` at each accepted request.
- Each response pops the tag and is pushed to the data FIFO as `{data, tag}`.
- `outstanding` increments on request acceptance and decrements on response. Both in the same cycle leaves it unchanged.

**Redirect handling (in the cycle `redirect_valid` = 1)**
- Next-cycle `fetch_pc` is `{redirect_pc[31:2], 2'b00}`.
- Data and tag FIFOs are cleared.
- `drop_cnt` is loaded with `outstanding` minus any response arriving this same cycle. That same-cycle response is discarded.
- No request is issued in the redirect cycle.
- While `drop_cnt != 0`, each response decrements `drop_cnt` and is discarded. These responses neither push nor decrement the credit count; `outstanding` counts only live requests.
- A redirect arriving while `drop_cnt != 0` adds the new live outstanding count to `drop_cnt`.

**Output**
- `out_*` is driven from the FIFO head. `out_valid = fifo_count != 0`.
- Pop occurs on `out_valid && out_ready`.
- If redirect and output handshake occur in the same cycle, the handshake completes (the decoder keeps the bundle) and the flush then clears the remainder.

## Timing

**Reset values**
- `imem_req_valid` = 0.
- `imem_req_addr` = `RESET_PC`.
- `out_valid` = 0.
- `out_instr` = `32'h0000_0013` (NOP).
- `out_pc` = `RESET_PC`; `out_pc_plus4` = `RESET_PC + 4`.
- All counters = 0.

**Reset mid-operation**
- Asynchronously clears all state.
- Responses to pre-reset requests are the memory's responsibility. The memory must be reset together with this block.

**Latency and throughput**
- Minimum latency from request acceptance to `out_valid` is memory latency + 1 cycle (registered FIFO write, FIFO head read).
- Sustained throughput is 1 instruction/cycle with 1-cycle memory latency and `FIFO_DEPTH` ≥ 2.

**FIFO boundaries**
- Full: requests are withheld.
- Empty: `out_valid` = 0.
- Simultaneous push and pop when full or empty are both legal and keep the count consistent.

## Configuration

- **`IFETCH_PERF_CNT_EN` defined:** adds output ports `perf_fetch_cnt[31:0]`, `perf_stall_cnt[31:0]` and `perf_flush_cnt[31:0]`.
  - `perf_fetch_cnt` increments per output handshake.
  - `perf_stall_cnt` increments per cycle with `out_ready && !out_valid`.
  - `perf_flush_cnt` increments per redirect cycle.
  - All three wrap at 2^32 and reset to 0.
- **Not defined:** these ports and counters do not exist. All other behaviour is identical.

## Structure

- **Shared package `riscv_pkg`** holds:
  - `XLEN` = 32.
  - `NOP_INSTR` = `32'h0000_0013`.
  - The opcode constants shared with the decoder: OP `7'b0110011`, OP-IMM `7'b0010011`, BRANCH `7'b1100011`, JAL `7'b1101111`, JALR `7'b1100111`, STORE `7'b0100011`.
  - Typedef `fetch_bundle_t` = `{instr, pc}`.
- **Sub-module `fetch_fifo`:** parameterised-width, parameterised-depth synchronous FIFO with a synchronous flush input. It is instantiated twice, once for PC tags and once for `{data, pc}` bundles.

## Test plan

1. **Reset and streaming:** `RESET_PC=32'h100`, 1-cycle memory, `out_ready`=1 → `out_pc` sequence `0x100, 0x104, 0x108…` at one per cycle, with `out_pc_plus4 = out_pc + 4`.
2. **Backpressure:** `out_ready`=0 for 10 cycles → at most `FIFO_DEPTH` requests accepted and `imem_req_valid` drops. On release, no bundle is lost or duplicated.
3. **Redirect with outstanding fetches:** 3-cycle memory latency, redirect to `0x2002` with 2 requests outstanding → both stale responses are dropped, and the next `out_pc` is `0x2000`.
4. **Simultaneous events:** redirect in the same cycle as an output handshake and an incoming response → the handshaked bundle is kept, the response is dropped, and the first post-redirect bundle is the target.
5. **Wrap-around:** redirect to `0xFFFF_FFFC` → next `out_pc` values are `0xFFFF_FFFC` then `0x0000_0000`, with `out_pc_plus4` = 0 for the first.
6. **Performance counters:** with `IFETCH_PERF_CNT_EN` defined, 5 fetches, 2 redirects and 3 starved cycles → the counters read 5 / 3 / 2.
